fetch_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 13 +
 rtl/pc_reg.sv | 30 +++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the mips32 pipeline front end.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam logic [5:0]  OPCODE_J  = 6'b000010;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load, hold and sequential-increment selects.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_load,
  input  logic [31:0] i_load_pc,
  input  logic        i_incr,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_incr) begin
      r_pc <= r_pc + PC_INCR;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// mips32 instruction-fetch stage: PC sequencing, IF/ID register, fault halt
// and a saturating count of instructions handed to decode.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int          CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [25:0]      JumpIndex,
  output logic [31:0]      Address,
  input  logic [31:0]      Instruction,
  output logic [31:0]      Pc,
  output logic [31:0]      IfIdInstr,
  output logic [31:0]      IfIdPcPlus4,
  output logic             IfIdValid,
  output logic             Fault,
  output logic [CNT_W-1:0] FetchCount
);

  localparam logic [31:0] LP_LIMIT = 32'(IMEM_BYTES);

  fetch_state_e     r_state;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc_plus4;
  logic             r_valid;
  logic             r_fault;
  logic [CNT_W-1:0] r_count;

  logic [31:0] w_pc;
  logic        w_active;
  logic        w_redirect;
  logic        w_pc_oob;
  logic [31:0] w_target;
  logic        w_unused_bits;

  // Redirects only count when decode actually holds the branch/jump.
  assign w_active   = (r_state == ST_RUN) && !Stall;
  assign w_redirect = r_valid && (Jump || BranchTaken);
  assign w_pc_oob   = (w_pc >= LP_LIMIT);
  assign w_target   = Jump ? {r_pc_plus4[31:28], JumpIndex, 2'b00}
                           : {BranchTarget[31:2], 2'b00};
  assign w_unused_bits = ^BranchTarget[1:0];

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_load    (w_active && w_redirect),
    .i_load_pc (w_target),
    .i_incr    (w_active && !w_redirect && !w_pc_oob),
    .o_pc      (w_pc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_RUN;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (Stall) begin
            r_state <= ST_RUN;
          end else if (w_redirect) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end else if (w_pc_oob) begin
            r_fault <= 1'b1;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_state <= ST_HALT;
          end else begin
            r_instr    <= Instruction;
            r_pc_plus4 <= w_pc + PC_INCR;
            r_valid    <= 1'b1;
            if (r_count != {CNT_W{1'b1}}) begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        ST_HALT: begin
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_HALT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Address     = w_pc;
  assign Pc          = w_pc;
  assign IfIdInstr   = r_instr;
  assign IfIdPcPlus4 = r_pc_plus4;
  assign IfIdValid   = r_valid;
  assign Fault       = r_fault;
  assign FetchCount  = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/reset traffic compared against a behavioural model.
module tb_fetch_stage;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned SMALL_MEM = 12;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [25:0] JumpIndex;

  logic [31:0] a_addr, a_instr_in, a_pc, a_instr, a_pcp4;
  logic        a_valid, a_fault;
  logic [15:0] a_cnt;
  logic [31:0] b_addr, b_instr_in, b_pc, b_instr, b_pcp4;
  logic        b_valid, b_fault;
  logic [15:0] b_cnt;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural reference state for the 1024-byte instance.
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid, m_fault, m_halt;
  int          m_cnt;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    if (addr < MEM_BYTES) return mem[addr[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign a_instr_in = mem_rd(a_addr);
  assign b_instr_in = mem_rd(b_addr);

  fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(MEM_BYTES), .CNT_W(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpIndex(JumpIndex),
    .Address(a_addr), .Instruction(a_instr_in), .Pc(a_pc), .IfIdInstr(a_instr),
    .IfIdPcPlus4(a_pcp4), .IfIdValid(a_valid), .Fault(a_fault), .FetchCount(a_cnt)
  );

  fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(SMALL_MEM), .CNT_W(16)) dut_b (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpIndex(JumpIndex),
    .Address(b_addr), .Instruction(b_instr_in), .Pc(b_pc), .IfIdInstr(b_instr),
    .IfIdPcPlus4(b_pcp4), .IfIdValid(b_valid), .Fault(b_fault), .FetchCount(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Next state from the fetch rules, evaluated with the inputs present before the edge.
  task automatic model_step();
    if (Reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0; m_cnt = 0;
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (Stall) begin
      m_valid = m_valid;
    end else if (m_valid && (Jump || BranchTaken)) begin
      if (Jump) m_pc = (m_pcp4 & 32'hF000_0000) | (32'(JumpIndex) * 4);
      else      m_pc = BranchTarget & ~32'd3;
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (m_pc >= MEM_BYTES) begin
      m_fault = 1'b1; m_halt = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = mem_rd(m_pc);
      m_pcp4  = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    check("pc",      a_pc,           m_pc);
    check("address", a_addr,         m_pc);
    check("ifid_instr", a_instr,     m_instr);
    check("ifid_pcp4",  a_pcp4,      m_pcp4);
    check("ifid_valid", 32'(a_valid), 32'(m_valid));
    check("fault",   32'(a_fault),   32'(m_fault));
    check("count",   32'(a_cnt),     32'(m_cnt));
  endtask

  task automatic idle_inputs();
    Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    Jump = 1'b0; JumpIndex = 26'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0002;
    mem[1] = 32'h2109_0004;
    mem[2] = 32'h0109_5020;
    m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0; m_cnt = 0;

    // Reset state
    idle_inputs();
    Reset = 1'b1;
    tick(); tick();
    check("rst_pc", a_pc, 32'h0);
    check("rst_valid", 32'(a_valid), 32'h0);
    check("rst_count", 32'(a_cnt), 32'h0);

    // Sequential fetch, then a two-cycle stall on the second instruction
    Reset = 1'b0;
    tick();
    check("seq0_instr", a_instr, 32'h2008_0002);
    check("seq0_pcp4", a_pcp4, 32'h4);
    tick();
    check("seq1_instr", a_instr, 32'h2109_0004);
    check("seq1_pcp4", a_pcp4, 32'h8);
    Stall = 1'b1;
    tick(); tick();
    check("stall_pc", a_pc, 32'h8);
    check("stall_instr", a_instr, 32'h2109_0004);
    check("stall_count", 32'(a_cnt), 32'd2);
    Stall = 1'b0;
    tick();
    check("seq2_instr", a_instr, 32'h0109_5020);
    check("seq2_pcp4", a_pcp4, 32'd12);
    check("seq2_pc", a_pc, 32'd12);
    check("seq2_count", 32'(a_cnt), 32'd3);

    // Taken branch with unaligned target: low bits dropped, one bubble
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0006;
    tick();
    check("br_pc", a_pc, 32'h4);
    check("br_valid", 32'(a_valid), 32'h0);
    check("br_instr", a_instr, 32'h0);
    idle_inputs();
    tick();
    check("br_target_instr", a_instr, 32'h2109_0004);

    // Jump and branch together: jump wins, IfIdPcPlus4 is 8 here
    check("jb_pcp4_pre", a_pcp4, 32'h8);
    Jump = 1'b1; JumpIndex = 26'h2; BranchTaken = 1'b1; BranchTarget = 32'h100;
    tick();
    check("jb_pc", a_pc, 32'h8);
    check("jb_valid", 32'(a_valid), 32'h0);
    idle_inputs();
    tick();

    // Redirect ignored while IF/ID empty; ignored again under stall
    Reset = 1'b1;
    tick();
    Reset = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h40;
    tick();
    check("br_novalid_pc", a_pc, 32'h4);
    Stall = 1'b1;
    tick();
    check("br_stall_pc", a_pc, 32'h4);
    idle_inputs();
    tick();

    // Fault on the 12-byte instance, holds through jump pulses until reset
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("flt_b_fault", 32'(b_fault), 32'h1);
    check("flt_b_pc", b_pc, 32'd12);
    check("flt_b_valid", 32'(b_valid), 32'h0);
    for (int i = 0; i < 10; i++) begin
      Jump = i[0]; JumpIndex = 26'h1;
      tick();
      check("halt_b_pc", b_pc, 32'd12);
      check("halt_b_fault", 32'(b_fault), 32'h1);
      check("halt_b_valid", 32'(b_valid), 32'h0);
    end
    check("halt_b_count", 32'(b_cnt), 32'd3);
    idle_inputs();
    Reset = 1'b1;
    tick();
    check("flt_rst_fault", 32'(b_fault), 32'h0);
    check("flt_rst_pc", b_pc, 32'h0);
    check("flt_rst_count", 32'(b_cnt), 32'h0);
    Reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      Reset        = ($urandom_range(0, 99) < 2);
      Stall        = ($urandom_range(0, 99) < 25);
      BranchTaken  = ($urandom_range(0, 99) < 15);
      BranchTarget = 32'($urandom_range(0, 1100));
      Jump         = ($urandom_range(0, 99) < 10);
      JumpIndex    = 26'($urandom_range(0, 300));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
